fpga_cfg_loader: RTL and testbench
==================================

FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 cfg_start  input  1  one-cycle request to begin a load; honoured only in IDLE or ERR.
REQ-005 cfg_data  input  8  bitstream byte.
REQ-006 cfg_valid  input  1  cfg_data valid.
REQ-007 cfg_ready  output  1  loader accepts a byte; a transfer occurs on an edge where cfg_valid and cfg_ready are both high.
REQ-008 cfg_busy  output  1  high in HDR, LOAD and CHK.
REQ-009 cfg_done  output  1  one-cycle pulse on a successful commit.
REQ-010 cfg_error  output  1  held high in ERR.
REQ-011 cfg_loaded  output  1  high once any commit has succeeded since reset.
REQ-012 brbselect  output  750  committed routing-block configuration.
REQ-013 bsbselect  output  1728  committed switch-block configuration.
REQ-014 lbselect  output  80  committed logic-block configuration.
REQ-015 leftioselect, rightioselect, topioselect, bottomioselect  output  20 each  committed IO configuration.

Function
REQ-016 Stream format SHALL be: header byte 0xA5, then 330 payload bytes, then 1 checksum byte equal to the XOR of all 330 payload bytes.
REQ-017 Payload bit k SHALL be byte k/8, bit k%8, LSB first.
REQ-018 Bits k=0..749 SHALL map to brbselect[0..749], and 750..2477 to bsbselect[0..1727].
REQ-019 Bits 2478..2557 SHALL map to lbselect[0..79].
REQ-020 Bits 2558..2577, 2578..2597, 2598..2617 and 2618..2637 SHALL map to left/right/top/bottomioselect[0..19] respectively; bits 2638 and 2639 SHALL be ignored.
REQ-021 Payload SHALL be assembled into a 2638-bit shadow register; committed outputs SHALL change only at a commit.
REQ-022 FSM states SHALL be IDLE, HDR, LOAD, CHK, ERR.
REQ-023 IDLE/ERR + cfg_start -> HDR; this clears cfg_error, the byte counter and the running XOR. In that cycle cfg_ready=0.
REQ-024 In HDR, a transfer of 0xA5 -> LOAD; a transfer of any other value -> ERR.
REQ-025 In LOAD, each transfer writes a byte into the shadow register, XORs it into the running checksum and increments a 9-bit counter; the transfer of byte 329 -> CHK.
REQ-026 In CHK, on the checksum transfer:
  - Match: on that same edge, copy the shadow register to all select outputs, pulse cfg_done for the following cycle, set cfg_loaded=1, and go to IDLE.
  - Mismatch: go to ERR with outputs unchanged.
REQ-027 cfg_ready SHALL be 1 exactly in HDR, LOAD and CHK.
REQ-028 cfg_valid low SHALL stall with no state change; the counter advances only on a transfer.
REQ-029 cfg_start outside IDLE/ERR SHALL be ignored.
REQ-030 cfg_start coincident with a transfer in IDLE/ERR SHALL discard the byte (cfg_ready=0).
REQ-031 ERR SHALL hold until cfg_start or reset; committed outputs and cfg_loaded SHALL be retained.
REQ-032 cfg_data SHALL be ignored whenever cfg_valid=0.

Reset
REQ-033 reset SHALL force: state IDLE; cfg_ready, cfg_busy, cfg_done, cfg_error and cfg_loaded to 0; all select outputs to 0; shadow register, counter and XOR to 0.
REQ-034 reset SHALL take priority over cfg_start and any transfer, including mid-LOAD and mid-CHK.

Verification
REQ-035 Reset -> all outputs 0 and cfg_ready=0; pulse cfg_start -> cfg_ready=1 and cfg_busy=1 from the next cycle.
REQ-036 Stream 0xA5, payload byte0=0x01 and all others 0x00, checksum 0x01 -> brbselect[0]=1, all other select bits 0, one cfg_done pulse, cfg_loaded=1.
REQ-037 Stream 0xA5, payload byte324=0x40 and all others 0x00, checksum 0x40 -> topioselect[0]=1 only.
REQ-038 After a good load, stream header 0x5A -> cfg_error=1, cfg_ready=0, outputs keep previous values; a subsequent cfg_start clears cfg_error.
REQ-039 Good stream but checksum 0x00 instead of 0x01 -> ERR, no cfg_done pulse, brbselect[0] retains its prior value.
REQ-040 Good stream with random cfg_valid gaps and reset asserted after 100 payload bytes -> state IDLE and all outputs 0; a repeated stream without the reset matches REQ-036.

Source files
------------

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: checks a 0xA5-framed, XOR-protected bitstream and commits it to the fabric select outputs
module fpga_cfg_loader (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_start,
  input  logic [7:0]      cfg_data,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  output logic            cfg_busy,
  output logic            cfg_done,
  output logic            cfg_error,
  output logic            cfg_loaded,
  output logic [749:0]    brbselect,
  output logic [1727:0]   bsbselect,
  output logic [79:0]     lbselect,
  output logic [19:0]     leftioselect,
  output logic [19:0]     rightioselect,
  output logic [19:0]     topioselect,
  output logic [19:0]     bottomioselect
);
  typedef enum logic [2:0] {IDLE, HDR, LOAD, CHK, ERR} state_t;
  state_t r_state, w_next;
  logic [8:0]    r_cnt;
  logic [7:0]    r_xor;
  logic [2631:0] r_shadow;
  logic [5:0]    r_tail;
  logic [2637:0] r_cfg;
  logic          r_done, r_loaded;
  logic          w_xfer, w_start, w_commit;
  assign cfg_ready = (r_state == HDR) || (r_state == LOAD) || (r_state == CHK);
  assign cfg_busy  = cfg_ready;
  assign cfg_error = r_state == ERR;
  assign cfg_done  = r_done;
  assign cfg_loaded = r_loaded;
  assign w_xfer   = cfg_valid && cfg_ready;
  assign w_start  = cfg_start && (r_state == IDLE || r_state == ERR);
  assign w_commit = r_state == CHK && w_xfer && cfg_data == r_xor;
  assign {bottomioselect, topioselect, rightioselect, leftioselect, lbselect, bsbselect, brbselect} = r_cfg;
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, ERR: w_next = w_start ? HDR : r_state;
      HDR:       w_next = !w_xfer ? HDR : (cfg_data == 8'hA5 ? LOAD : ERR);
      LOAD:      w_next = (w_xfer && r_cnt == 9'd329) ? CHK : LOAD;
      CHK:       w_next = !w_xfer ? CHK : (w_commit ? IDLE : ERR);
      default:   w_next = IDLE;
    endcase
  end
  // Bytes 0..328 shift in LSB-first so byte 0 lands at bit 0; byte 329 contributes only its low 6 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_xor    <= '0;
      r_shadow <= '0;
      r_tail   <= '0;
      r_cfg    <= '0;
      r_done   <= 1'b0;
      r_loaded <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_commit) begin
        r_cfg    <= {r_tail, r_shadow};
        r_loaded <= 1'b1;
      end
      if (w_start) begin
        r_cnt <= '0;
        r_xor <= '0;
      end
      if (r_state == LOAD && w_xfer) begin
        r_cnt <= r_cnt + 9'd1;
        r_xor <= r_xor ^ cfg_data;
        if (r_cnt == 9'd329) r_tail <= cfg_data[5:0];
        else                 r_shadow <= {cfg_data, r_shadow[2631:8]};
      end
    end
  end
endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb_fpga_cfg_loader: frame-level model of the loader checked every cycle, plus literal expectations
module tb_fpga_cfg_loader;
  logic clk = 1'b0;
  logic reset, cfg_start, cfg_valid;
  logic [7:0] cfg_data;
  logic cfg_ready, cfg_busy, cfg_done, cfg_error, cfg_loaded;
  logic [749:0]  brbselect;
  logic [1727:0] bsbselect;
  logic [79:0]   lbselect;
  logic [19:0]   leftioselect, rightioselect, topioselect, bottomioselect;
  logic [2637:0] w_all;
  int n_vec = 0, n_bad = 0, n_done = 0;
  logic [7:0] pl_in [330];

  fpga_cfg_loader dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
    .cfg_loaded(cfg_loaded), .brbselect(brbselect), .bsbselect(bsbselect), .lbselect(lbselect),
    .leftioselect(leftioselect), .rightioselect(rightioselect), .topioselect(topioselect),
    .bottomioselect(bottomioselect)
  );

  always #5 clk = ~clk;
  assign w_all = {bottomioselect, topioselect, rightioselect, leftioselect, lbselect, bsbselect, brbselect};

  // Model: mode 0 idle, 1 in a frame, 2 error; pos counts bytes taken in the current frame
  int m_mode = 0, m_pos = 0;
  logic [7:0] m_pl [330];
  logic [2637:0] m_cfg = '0;
  logic m_done = 1'b0, m_loaded = 1'b0;

  always @(posedge clk) begin : model
    logic [7:0] x;
    if (reset) begin
      m_mode = 0; m_pos = 0; m_cfg = '0; m_done = 1'b0; m_loaded = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_mode != 1) begin
        if (cfg_start) begin m_mode = 1; m_pos = 0; end
      end else if (cfg_valid) begin
        if (m_pos == 0) begin
          if (cfg_data == 8'hA5) m_pos = 1; else m_mode = 2;
        end else if (m_pos <= 330) begin
          m_pl[m_pos-1] = cfg_data;
          m_pos++;
        end else begin
          x = 8'h00;
          for (int i = 0; i < 330; i++) x ^= m_pl[i];
          if (cfg_data == x) begin
            for (int k = 0; k < 2638; k++) m_cfg[k] = m_pl[k/8][k%8];
            m_loaded = 1'b1; m_done = 1'b1; m_mode = 0;
          end else m_mode = 2;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [4:0] got, exp;
    int first;
    exp = {m_mode == 1, m_mode == 1, m_done, m_mode == 2, m_loaded};
    got = {cfg_ready, cfg_busy, cfg_done, cfg_error, cfg_loaded};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL status(ready,busy,done,error,loaded) got=%b exp=%b t=%0t", got, exp, $time);
    end
    n_vec++;
    if (w_all !== m_cfg) begin
      n_bad++;
      first = -1;
      for (int k = 2637; k >= 0; k--) if (w_all[k] !== m_cfg[k]) first = k;
      $display("FAIL select bit %0d got=%b exp=%b t=%0t", first, w_all[first], m_cfg[first], $time);
    end
    if (cfg_done) n_done++;
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic fill(input int idx, input logic [7:0] v);
    for (int i = 0; i < 330; i++) pl_in[i] = 8'h00;
    if (idx >= 0) pl_in[idx] = v;
  endtask

  task automatic put(input logic [7:0] b, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) begin
      cfg_valid = 1'b0; cfg_data = 8'($urandom); tick;
    end
    cfg_valid = 1'b1; cfg_data = b; tick;
    cfg_valid = 1'b0; cfg_data = 8'($urandom);
  endtask

  task automatic frame(input logic [7:0] hdr, input bit bad, input bit gaps, input int ra);
    logic [7:0] x;
    x = 8'h00;
    cfg_start = 1'b1; tick; cfg_start = 1'b0;
    put(hdr, gaps);
    if (hdr != 8'hA5) return;
    for (int i = 0; i < 330; i++) begin
      if (i == ra) begin reset = 1'b1; tick; reset = 1'b0; return; end
      put(pl_in[i], gaps);
      x ^= pl_in[i];
    end
    if (ra == 330) begin reset = 1'b1; tick; reset = 1'b0; return; end
    put(bad ? x ^ 8'h01 : x, gaps);
  endtask

  initial begin
    int d;
    reset = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
    repeat (3) tick;
    lit("rst_ready", 32'(cfg_ready), 0);
    lit("rst_sel_ones", $countones(w_all), 0);
    lit("rst_loaded", 32'(cfg_loaded), 0);
    reset = 1'b0; tick;
    cfg_start = 1'b1; tick; cfg_start = 1'b0;
    lit("start_ready_busy", {cfg_ready, cfg_busy}, 2'b11);
    fill(0, 8'h01); frame(8'hA5, 0, 0, -1);
    lit("r036_done", 32'(cfg_done), 1);
    tick;
    lit("r036_brb0", 32'(brbselect[0]), 1);
    lit("r036_ones", $countones(w_all), 1);
    lit("r036_loaded", 32'(cfg_loaded), 1);
    lit("r036_pulses", n_done, 1);
    fill(324, 8'h40); frame(8'hA5, 0, 0, -1); tick;
    lit("r037_top", 32'(topioselect), 1);
    lit("r037_ones", $countones(w_all), 1);
    fill(329, 8'hFF); frame(8'hA5, 0, 0, -1); tick;
    lit("byte329_bottom", 32'(bottomioselect), 32'hFC000);
    lit("byte329_ones", $countones(w_all), 6);
    for (int i = 0; i < 330; i++) pl_in[i] = 8'($urandom);
    frame(8'hA5, 0, 0, -1); tick;
    fill(0, 8'h01); frame(8'hA5, 0, 0, -1); tick;
    frame(8'h5A, 0, 0, -1);
    lit("r038_error", 32'(cfg_error), 1);
    lit("r038_ready", 32'(cfg_ready), 0);
    lit("r038_brb0", 32'(brbselect[0]), 1);
    tick;
    cfg_start = 1'b1; tick; cfg_start = 1'b0;
    lit("r038_clear", 32'(cfg_error), 0);
    fill(324, 8'h40); frame(8'hA5, 0, 0, -1); tick;
    d = n_done;
    fill(0, 8'h01); frame(8'hA5, 1, 0, -1); tick;
    lit("r039_error", 32'(cfg_error), 1);
    lit("r039_pulses", n_done - d, 0);
    lit("r039_brb0", 32'(brbselect[0]), 0);
    lit("r039_top", 32'(topioselect), 1);
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hA5; tick;
    cfg_start = 1'b0; cfg_valid = 1'b0;
    lit("r030_hdr_ready", 32'(cfg_ready), 1);
    put(8'h00, 0);
    lit("r030_discard", 32'(cfg_error), 1);
    fill(0, 8'h01); frame(8'hA5, 0, 1, 100);
    lit("r040_ones", $countones(w_all), 0);
    lit("r040_loaded", 32'(cfg_loaded), 0);
    lit("r040_ready", 32'(cfg_ready), 0);
    frame(8'hA5, 0, 1, -1); tick;
    lit("r040_brb0", 32'(brbselect[0]), 1);
    lit("r040_ones2", $countones(w_all), 1);
    lit("r040_loaded2", 32'(cfg_loaded), 1);
    fill(5, 8'h33); frame(8'hA5, 0, 0, 330);
    lit("chk_reset_ones", $countones(w_all), 0);
    lit("chk_reset_ready", 32'(cfg_ready), 0);
    repeat (3) tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
